// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: pipelined imem requests, DEPTH-entry prefetch FIFO toward ID,
// redirect flush with discard of stale in-flight responses.
module if_prefetch_queue #(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = 32'h8000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [XLEN-1:0]          imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [XLEN-1:0]          id_pc,
  output logic [31:0]              id_instr,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW:0]   DEPTH_L = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] MAXO_L  = CW'(MAX_OUTSTANDING);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [XLEN-1:0] tag_pc [MAX_OUTSTANDING];
  logic [TW-1:0]   tag_wr, tag_rd;
  logic [XLEN-1:0] fifo_pc    [DEPTH];
  logic [31:0]     fifo_instr [DEPTH];
  logic [CW-1:0]   wr_ptr, rd_ptr;

  logic fifo_empty, req_fire, rsp_accept, rsp_live, pop;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
  endfunction

  assign occupancy     = wr_ptr - rd_ptr;
  assign fifo_empty    = (wr_ptr == rd_ptr);
  assign imem_req_addr = fetch_pc;
  assign id_valid      = !fifo_empty;
  assign id_pc         = fifo_pc[rd_ptr[AW-1:0]];
  assign id_instr      = fifo_instr[rd_ptr[AW-1:0]];

  // Counting in-flight requests against free FIFO slots guarantees every live response lands.
  assign imem_req_valid = !rst && !redirect_valid && (outstanding < MAXO_L)
                          && (({1'b0, occupancy} + {1'b0, outstanding}) < DEPTH_L);

  assign req_fire   = imem_req_valid && imem_req_ready;
  assign rsp_accept = imem_rsp_valid && (outstanding != '0);
  assign rsp_live   = rsp_accept && (drop_cnt == '0) && !redirect_valid;
  assign pop        = id_valid && id_ready && !redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) tag_pc[i] <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old stream.
      fetch_pc    <= redirect_pc & ~XLEN'(3);
      outstanding <= outstanding - CW'(rsp_accept);
      drop_cnt    <= outstanding - CW'(rsp_accept);
      tag_wr      <= '0;
      tag_rd      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (req_fire) begin
        fetch_pc       <= fetch_pc + XLEN'(4);
        tag_pc[tag_wr] <= fetch_pc;
        tag_wr         <= tag_inc(tag_wr);
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_accept);
      if (rsp_accept && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      if (rsp_live) begin
        fifo_pc[wr_ptr[AW-1:0]]    <= tag_pc[tag_rd];
        fifo_instr[wr_ptr[AW-1:0]] <= imem_rsp_data;
        wr_ptr                     <= wr_ptr + CW'(1);
        tag_rd                     <= tag_inc(tag_rd);
      end
      if (pop) rd_ptr <= rd_ptr + CW'(1);
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && imem_rsp_valid && (outstanding == '0))
      $error("if_prefetch_queue: imem response with no request outstanding");
  end
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: directed cycle table, redirect/reset sequences and random traffic
// against a stream-level model (expected PC sequence, pending-request queue, FIFO fill count).
module tb_if_prefetch_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc, id_instr;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  if_prefetch_queue #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
    .occupancy(occupancy)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  typedef struct {
    bit          ir;
    bit          rv;
    bit          iv;
    logic [31:0] pc;
    int          occ;
  } vec_t;

  pend_t       pend[$];
  int          checks = 0, errors = 0, cyc = 0, model_occ = 0, delivered = 0;
  logic [31:0] exp_req = RPC, exp_pc = RPC;
  logic        s_req_valid, s_id_valid;
  logic [31:0] s_req_addr, s_id_pc;
  int          s_occ;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0000_1357;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check DUT against the model, advance the model.
  task automatic step(input bit rr, input bit ir, input bit redir, input logic [31:0] rpc, input int dly);
    bit          rsp, rstale, credit;
    @(negedge clk);
    rsp = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_req_ready = rr;
    id_ready       = ir;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem(pend[0].addr) : 32'hDEAD_BEEF;
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_id_valid  = id_valid;
    s_id_pc     = id_pc;
    s_occ       = int'(occupancy);
    credit = !redir && (pend.size() < MAXO) && ((model_occ + pend.size()) < DEPTH);
    check("occupancy", 32'(occupancy), 32'(model_occ));
    check("id_valid", 32'(id_valid), 32'(model_occ > 0));
    check("req_valid", 32'(imem_req_valid), 32'(credit));
    rstale = 1'b0;
    if (rsp) begin
      rstale = pend[0].stale;
      void'(pend.pop_front());
    end
    if (redir) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      model_occ = 0;
      exp_req   = rpc & ~32'd3;
      exp_pc    = rpc & ~32'd3;
    end else begin
      if (model_occ > 0 && ir) begin
        check("id_pc", id_pc, exp_pc);
        check("id_instr", id_instr, mem(exp_pc));
        exp_pc += 32'd4;
        model_occ--;
        delivered++;
      end
      if (rsp && !rstale) model_occ++;
      if (imem_req_valid && rr) begin
        check("req_addr", imem_req_addr, exp_req);
        pend.push_back('{addr: imem_req_addr, due: cyc + dly, stale: 1'b0});
        exp_req += 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    vec_t tbl[15];
    bit   found;
    int   target;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RPC);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_id_instr", id_instr, 32'd0);
    rst = 1'b0;

    // Fill, then 10-cycle ID stall saturating the FIFO, then drain
    for (int i = 0; i < 15; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 32'h8000_0004, 4};
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h8000_0000, 1};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h8000_0004, 1};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h8000_0004, 2};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h8000_0004, 3};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 32'h8000_0004, 4};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 32'h8000_0008, 3};
    for (int i = 0; i < 15; i++) begin
      step(1'b1, tbl[i].ir, 1'b0, 32'h0, 1);
      check("tbl_req_valid", 32'(s_req_valid), 32'(tbl[i].rv));
      check("tbl_id_valid", 32'(s_id_valid), 32'(tbl[i].iv));
      check("tbl_occupancy", 32'(s_occ), 32'(tbl[i].occ));
      if (tbl[i].iv) check("tbl_id_pc", s_id_pc, tbl[i].pc);
    end

    // Redirect with two requests in flight
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      if (pend.size() == 2) found = 1'b1;
      else step(1'b1, 1'b1, 1'b0, 32'h0, 3);
    end
    check("o2_reached", 32'(found), 32'd1);
    step(1'b1, 1'b1, 1'b1, 32'h8000_0103, 1);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 1);
      if (s_req_valid) begin
        found = 1'b1;
        check("redir_req_addr", s_req_addr, 32'h8000_0100);
      end
    end
    check("redir_req_seen", 32'(found), 32'd1);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1);
      if (s_id_valid) begin
        found = 1'b1;
        check("redir_first_id_pc", s_id_pc, 32'h8000_0100);
      end
    end
    check("redir_id_seen", 32'(found), 32'd1);

    // Redirect coinciding with the only outstanding response
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      if (pend.size() == 1 && pend[0].due <= cyc && !pend[0].stale) found = 1'b1;
      else step(pend.size() == 0, 1'b1, 1'b0, 32'h0, 2);
    end
    check("o1_rsp_reached", 32'(found), 32'd1);
    step(1'b0, 1'b1, 1'b1, 32'h8000_0200, 1);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1);
      if (s_id_valid) begin
        found = 1'b1;
        check("coinc_first_id_pc", s_id_pc, 32'h8000_0200);
      end
    end
    check("coinc_id_seen", 32'(found), 32'd1);

    // Random handshakes and delays, no redirects: 1000 instructions in order
    target = delivered + 1000;
    for (int n = 0; n < 20000 && delivered < target; n++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0, 32'h0, int'($urandom_range(1, 3)));
    check("random_1000_delivered", 32'(delivered >= target), 32'd1);

    // Random traffic with occasional redirects, some near the top of the address space
    for (int n = 0; n < 800; n++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 1) != 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0),
           rpc, int'($urandom_range(1, 3)));
    end

    // Reset in the middle of a stream with two requests in flight
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      if (pend.size() == 2) found = 1'b1;
      else step(1'b1, 1'b1, 1'b0, 32'h0, 3);
    end
    check("rst_o2_reached", 32'(found), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("midrst_id_valid", 32'(id_valid), 32'd0);
    check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    check("midrst_req_addr", imem_req_addr, RPC);
    check("midrst_occupancy", 32'(occupancy), 32'd0);
    pend.delete();
    model_occ = 0;
    exp_req   = RPC;
    exp_pc    = RPC;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    check("postrst_req_valid", 32'(s_req_valid), 32'd1);
    check("postrst_req_addr", s_req_addr, RPC);
    for (int n = 0; n < 6; n++) step(1'b1, 1'b1, 1'b0, 32'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
